// File: rtl/unified_mem_if.sv
// unified_mem_if: fetch, data and loader signals of the unified memory.
// master drives requests, slave is the memory.
interface unified_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_data;
  logic                  if_valid;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;
  logic                  ld_start;
  logic                  ld_valid;
  logic [7:0]            ld_byte;
  logic                  ld_ready;
  logic                  ld_done;
  logic                  busy;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_be, d_wdata,
    output ld_start, ld_valid, ld_byte, ld_done,
    input  if_data, if_valid, d_rdata, d_valid,
    input  ld_ready, busy
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_be, d_wdata,
    input  ld_start, ld_valid, ld_byte, ld_done,
    output if_data, if_valid, d_rdata, d_valid,
    output ld_ready, busy
  );
endinterface

// File: rtl/unified_mem.sv
// unified_mem: unified I/D memory with registered fetch/data ports,
// byte-serial program loader and power-up clear sequence.
module unified_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  unified_mem_if.slave  bus
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic [IDX_W-1:0]    ld_ptr_q, ld_ptr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   ld_word_q, ld_word_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [IDX_W-1:0]    mem_widx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;
  logic [DATA_W-1:0]   word_n;
  logic [LANE_W-1:0]   lane_n;
  logic                lane_full;

  logic [IDX_W-1:0]    if_idx, d_idx;
  logic                if_oor, d_oor;

  assign if_idx = bus.if_addr[IDX_W-1:0];
  assign d_idx  = bus.d_addr[IDX_W-1:0];
  assign if_oor = (bus.if_addr >> IDX_W) != '0;
  assign d_oor  = (bus.d_addr >> IDX_W) != '0;

  assign bus.if_data  = if_data_q;
  assign bus.if_valid = if_valid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.ld_ready = (state_q == LOAD);
  assign bus.busy     = (state_q != RUN);

  // next state, read capture, and the single memory write port
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_ptr_d   = ld_ptr_q;
    lane_d     = lane_q;
    ld_word_d  = ld_word_q;
    if_data_d  = if_data_q;
    if_valid_d = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_valid_d  = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = '0;
    mem_wdata  = '0;
    mem_wbe    = '0;
    word_n     = ld_word_q;
    lane_n     = lane_q;
    lane_full  = (lane_q == LANE_W'(NB - 1));
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_ptr_q;
        mem_wbe   = '1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDX_W'(DEPTH - 1))
          state_d = RUN;
      end
      RUN: begin
        if (bus.if_req) begin
          if_valid_d = 1'b1;
          if_data_d  = if_oor ? '0 : mem_q[if_idx];
        end
        if (bus.d_req) begin
          d_valid_d = 1'b1;
          d_rdata_d = d_oor ? '0 : mem_q[d_idx];
          if (bus.d_we && !d_oor) begin
            mem_we    = 1'b1;
            mem_widx  = d_idx;
            mem_wdata = bus.d_wdata;
            mem_wbe   = bus.d_be;
          end
        end
        if (bus.ld_start) begin
          state_d   = LOAD;
          ld_ptr_d  = '0;
          lane_d    = '0;
          ld_word_d = '0;
        end
      end
      LOAD: begin
        if (bus.ld_start) begin
          ld_ptr_d  = '0;
          lane_d    = '0;
          ld_word_d = '0;
        end else begin
          if (bus.ld_valid) begin
            for (int k = 0; k < NB; k++)
              if (lane_q == LANE_W'(k))
                word_n[8*k +: 8] = bus.ld_byte;
            if (lane_full) begin
              mem_we    = 1'b1;
              mem_widx  = ld_ptr_q;
              mem_wdata = word_n;
              mem_wbe   = '1;
              ld_ptr_d  = ld_ptr_q + 1'b1;
              lane_n    = '0;
              word_n    = '0;
            end else begin
              lane_n = lane_q + 1'b1;
            end
          end
          // unfilled lanes are already zero: word_n restarts at 0
          if (bus.ld_done) begin
            if (lane_n != '0) begin
              mem_we    = 1'b1;
              mem_widx  = ld_ptr_q;
              mem_wdata = word_n;
              mem_wbe   = '1;
            end
            state_d = RUN;
            lane_n  = '0;
            word_n  = '0;
          end
          lane_d    = lane_n;
          ld_word_d = word_n;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      ld_ptr_q   <= '0;
      lane_q     <= '0;
      ld_word_q  <= '0;
      if_data_q  <= '0;
      if_valid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ld_ptr_q   <= ld_ptr_d;
      lane_q     <= lane_d;
      ld_word_q  <= ld_word_d;
      if_data_q  <= if_data_d;
      if_valid_q <= if_valid_d;
      d_rdata_q  <= d_rdata_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // storage array; zeroed by the clear sequence instead of reset
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < NB; k++)
        if (mem_wbe[k])
          mem_q[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_unified_mem.sv
// tb_unified_mem: directed stimulus with a queue scoreboard
// checked by a monitor on the falling edge.
module tb_unified_mem;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  unified_mem #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] if_exp [$];
  logic [31:0] d_exp  [$];
  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] lbytes [6] = '{8'h13, 8'h00, 8'h10, 8'h00, 8'hEF, 8'hBE};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(logic [31:0] a, logic [31:0] e);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    if_exp.push_back(e);
    tick();
    bus.if_req = 1'b0;
    chk("if_valid", 32'(bus.if_valid), 32'd1);
  endtask

  task automatic dacc(logic we, logic [31:0] a, logic [31:0] wd,
                      logic [3:0] be, logic [31:0] e);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_be    = be;
    d_exp.push_back(e);
    tick();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    chk("d_valid", 32'(bus.d_valid), 32'd1);
  endtask

  task automatic wait_clear();
    repeat (DEPTH - 1) tick();
    chk("busy_during_clear", 32'(bus.busy), 32'd1);
    tick();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    chk("busy_after_clear", 32'(bus.busy), 32'd0);
  endtask

  // scoreboard monitor: every valid strobe pops one expectation
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.if_valid === 1'b1) begin
      if (if_exp.size() == 0) chk("if_unexpected", 32'd1, 32'd0);
      else begin
        e = if_exp.pop_front();
        chk("if_data", bus.if_data, e);
      end
    end
    if (bus.d_valid === 1'b1) begin
      if (d_exp.size() == 0) chk("d_unexpected", 32'd1, 32'd0);
      else begin
        e = d_exp.pop_front();
        chk("d_rdata", bus.d_rdata, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_be = 0; bus.d_wdata = 0;
    bus.ld_start = 0; bus.ld_valid = 0;
    bus.ld_byte = 0; bus.ld_done = 0;
    tick();
    tick();
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);

    // requests held during clear must be ignored
    rst = 1'b0;
    bus.if_req = 1; bus.if_addr = 5;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 5;
    bus.d_wdata = 32'hFFFF_FFFF; bus.d_be = 4'hF;
    wait_clear();
    chk("ld_ready_run", 32'(bus.ld_ready), 32'd0);

    fetch(0, 0);
    fetch(17, 0);
    fetch(31, 0);
    dacc(0, 17, 0, 0, 0);
    dacc(0, 5, 0, 0, 0);

    // byte enables
    dacc(1, 5, 32'hAABB_CCDD, 4'b1111, 32'h0);
    dacc(1, 5, 32'h1122_3344, 4'b0101, 32'hAABB_CCDD);
    dacc(0, 5, 0, 0, 32'hAA22_CC44);
    tick();
    chk("d_valid_idle", 32'(bus.d_valid), 32'd0);
    chk("d_rdata_hold", bus.d_rdata, 32'hAA22_CC44);

    // loader; fetches during load must be ignored
    bus.ld_start = 1;
    tick();
    bus.ld_start = 0;
    chk("ld_ready_load", 32'(bus.ld_ready), 32'd1);
    chk("busy_load", 32'(bus.busy), 32'd1);
    bus.if_req = 1; bus.if_addr = 0;
    for (int i = 0; i < 6; i++) begin
      bus.ld_valid = 1;
      bus.ld_byte  = lbytes[i];
      tick();
    end
    bus.ld_valid = 0;
    bus.ld_done  = 1;
    tick();
    bus.ld_done = 0;
    bus.if_req  = 0;
    chk("ld_ready_done", 32'(bus.ld_ready), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd0);
    dacc(0, 0, 0, 0, 32'h0010_0013);
    dacc(0, 1, 0, 0, 32'h0000_BEEF);
    fetch(1, 32'h0000_BEEF);
    fetch(5, 32'hAA22_CC44);

    // out of range
    dacc(0, 32, 0, 0, 32'h0);
    dacc(1, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0);
    fetch(32'h8000_0000, 32'h0);
    fetch(0, 32'h0010_0013);

    // fetch/write collision
    dacc(1, 3, 32'd1, 4'hF, 32'h0);
    bus.if_req = 1; bus.if_addr = 3;
    if_exp.push_back(32'd1);
    dacc(1, 3, 32'd2, 4'hF, 32'd1);
    bus.if_req = 0;
    fetch(3, 32'd2);

    // ld_done with a byte in the same cycle
    bus.ld_start = 1;
    tick();
    bus.ld_start = 0;
    bus.ld_valid = 1; bus.ld_byte = 8'hAA;
    tick();
    bus.ld_byte = 8'hBB;
    tick();
    bus.ld_byte = 8'hCC; bus.ld_done = 1;
    tick();
    bus.ld_valid = 0; bus.ld_done = 0;
    fetch(0, 32'h00CC_BBAA);
    dacc(0, 1, 0, 0, 32'h0000_BEEF);

    // reset in the middle of a load
    bus.ld_start = 1;
    tick();
    bus.ld_start = 0;
    bus.ld_valid = 1; bus.ld_byte = 8'h11;
    tick();
    bus.ld_byte = 8'h22;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("mid_rst_if_data", bus.if_data, 32'd0);
    chk("mid_rst_d_rdata", bus.d_rdata, 32'd0);
    tick();
    bus.ld_valid = 0;
    rst = 1'b0;
    wait_clear();
    fetch(0, 0);
    dacc(0, 1, 0, 0, 0);
    dacc(1, 2, 32'h1234_5678, 4'hF, 0);
    fetch(2, 32'h1234_5678);

    tick();
    tick();
    chk("if_queue_empty", 32'(if_exp.size()), 32'd0);
    chk("d_queue_empty", 32'(d_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/unified_mem.md
# unified_mem

Parametrised unified instruction/data memory for the RISC core. It provides a 1-cycle registered fetch read port and a data read/write port with byte enables. A byte-serial loader port fills memory with a program after reset. A hardware clear sequence zeroes every word after reset before any access is accepted.

## Interface
- DATA_W, 32, word width in bits; multiple of 8
- DEPTH, 32, number of words; power of two, ≥ 2
- ADDR_W, 32, width of the word-index address inputs
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch word index
- if_data  out  DATA_W  fetch read data
- if_valid  out  1  if_data valid
- d_req  in  1  data-port request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word index
- d_be  in  DATA_W/8  byte-lane write enables
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  data read result
- d_valid  out  1  data-port response strobe
- ld_start  in  1  enter load mode, pointer to word 0
- ld_valid  in  1  ld_byte valid
- ld_byte  in  8  loader byte
- ld_ready  out  1  loader can accept a byte
- ld_done  in  1  end load, flush partial word
- busy  out  1  clear or load in progress

## Operation
- States:
  - CLEAR: entered on reset. Counter clr_ptr writes 0 to mem[clr_ptr] each cycle, 0..DEPTH-1. After the DEPTH-1 write, go to RUN.
  - RUN: normal access.
  - LOAD: byte loading.
- Address decode: idx = addr[log2(DEPTH)-1:0]. If any bit at or above log2(DEPTH) is set, the address is out of range. Out-of-range reads return 0, still with valid asserted. Out-of-range writes are dropped, and d_valid still pulses.
- RUN, fetch: if_req samples if_addr and registers mem[idx] into if_data.
- RUN, data read: d_req & !d_we registers mem[idx] into d_rdata.
- RUN, data write: d_req & d_we updates only the lanes with d_be[k]=1, byte k = bits 8k+7:8k. d_rdata returns the pre-write word.
- Collision: a fetch and a data write to the same index in the same cycle returns the old word on if_data. The write takes effect at that edge.
- RUN to LOAD on ld_start. ld_ptr=0, lane=0. ld_start in LOAD restarts at word 0 and discards the partial word.
- LOAD:
  - ld_ready=1. Each ld_valid & ld_ready cycle stores ld_byte in lane `lane`, little-endian, first byte = bits 7:0.
  - On the last lane (DATA_W/8-1), the assembled word is written to mem[ld_ptr] at that edge. Then ld_ptr++ (wraps DEPTH-1 → 0) and lane=0.
- ld_done in LOAD:
  - If lane≠0, the partial word is written with unfilled lanes = 0.
  - A byte accepted in the same cycle is included first.
  - Then go to RUN.
- ld_done in RUN/CLEAR is ignored. ld_start during CLEAR is ignored.
- During CLEAR and LOAD, if_req and d_req are ignored: no valid, no writes. ld_ready=0 outside LOAD.
- busy = 1 in CLEAR and LOAD.

## Timing
- Reset values: if_data=0, d_rdata=0, if_valid=0, d_valid=0, ld_ready=0, busy=1, state=CLEAR, clr_ptr=0, ld_ptr=0, lane=0.
- Clear takes exactly DEPTH cycles after rst deasserts. busy falls on the edge that completes the last clear write. The first access is accepted in the following cycle.
- Read latency is 1 cycle. Request sampled at edge N gives valid=1 and data stable from edge N to edge N+1.
- Valid pulses for one cycle per accepted request. Back-to-back requests give continuous valid.
- if_data and d_rdata hold their last value when valid=0.
- A word write from a load is visible to a RUN read issued the cycle after the state returns to RUN.
- rst asserted mid-load or mid-access immediately returns all outputs to reset values, aborts any partial word, and restarts CLEAR.

## Test plan
- Clear: deassert rst, DEPTH=32 → busy high 32 cycles. Then reads of idx 0, 17 and 31 return 0 with if_valid one cycle after the request.
- Byte-enable write: write 0xAABBCCDD with be=4'b1111 to idx 5, then 0x11223344 with be=4'b0101. Read idx 5 → 0xAA22CC44. The second write's d_rdata = 0xAABBCCDD.
- Loader: ld_start, then bytes 0x13,0x00,0x10,0x00,0xEF,0xBE, then ld_done → mem[0]=0x00100013, mem[1]=0x0000BEEF. ld_ready is low after ld_done.
- Out of range: read addr 32 → d_rdata=0, d_valid=1. Write 0xFFFFFFFF to addr 0x40 → mem[0] unchanged.
- Collision: mem[3]=1. Same cycle: fetch idx 3 and write 2 to idx 3 → if_data=1. Next fetch of idx 3 → 2.
- Reset mid-load: rst during byte 2 of word 0 → busy=1, ld_ready=0. After clear, mem[0]=0 and requests are accepted again.
